// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Resolves load-use stalls, branch/jump flushes and data-memory waits (with
// an optional timeout), and keeps saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_mem_read_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             exmem_mem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             pipe_hold_o,
    output logic             memwb_bubble_o,
    output logic             mem_err_o,
    output logic             wait_state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Wait counter must be able to hold TIMEOUT itself; at least one bit.
    localparam int unsigned WaitW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT);
    localparam bit TimeoutEn = (TIMEOUT != 0);

    typedef enum logic [0:0] {StRun, StWait} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_busy;
    logic timeout_hit;
    logic freeze;
    logic load_use;
    logic redirect;

    // Hazard detection terms.
    always_comb begin
        mem_busy    = exmem_mem_req_i & ~dmem_ready_i;
        timeout_hit = TimeoutEn & (state_q == StWait) & (wait_cnt_q == TimeoutVal);
        freeze      = mem_busy & ~timeout_hit;
        load_use    = idex_mem_read_i & (idex_rt_i != 5'd0) &
                      ((idex_rt_i == ifid_rs_i) |
                       (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));
        redirect    = branch_taken_i | jump_i;
    end

    // Prioritised pipeline controls: freeze > load-use > redirect > normal.
    always_comb begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        pipe_hold_o    = 1'b0;
        memwb_bubble_o = 1'b0;
        if (!rst_ni) begin
            memwb_bubble_o = 1'b1;
        end else if (freeze) begin
            pipe_hold_o    = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (load_use) begin
            // Branch in ID is suppressed; it re-resolves once the load lands.
            idex_flush_o = 1'b1;
        end else if (redirect) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
        end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
        end
        // A ready response in the timeout cycle wins, so no error then.
        mem_err_o    = rst_ni & timeout_hit & mem_busy;
        wait_state_o = rst_ni & (state_q == StWait);
    end

    // Memory-wait FSM next state.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                if (freeze) begin
                    state_d    = StWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StWait: begin
                // Ready, dropped request or timeout all release the pipeline.
                if (!mem_busy || timeout_hit) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating performance counter next state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // FSM state and wait counter; reset abandons any pending access.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Performance counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
